// File: rtl/mux_arb_nto1.sv
// N-to-1 arbitrated data mux with a one-deep registered output stage.
// Channel selection is fixed-priority or round-robin, chosen per cycle by mode_i.
module mux_arb_nto1 #(
  parameter int size     = 32,
  parameter int channels = 4,
  parameter int sel_w    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mode_i,
  input  logic [channels-1:0]      valid_i,
  input  logic [channels*size-1:0] data_i,
  output logic [channels-1:0]      ready_o,
  output logic [size-1:0]          data_o,
  output logic                     valid_o,
  output logic [sel_w-1:0]         grant_o,
  input  logic                     ready_i
);

  localparam logic [sel_w-1:0] LastIdx = sel_w'(channels - 1);
  localparam logic [sel_w-1:0] OneIdx  = sel_w'(1);

  logic [sel_w-1:0] ptr_q, ptr_d;
  logic [sel_w-1:0] grant_q, grant_d;
  logic [size-1:0]  data_q, data_d;
  logic             valid_q, valid_d;

  logic             load_s;
  logic [sel_w-1:0] start_s;
  logic             win_found_s;
  logic [sel_w-1:0] win_idx_s;
  logic [size-1:0]  win_data_s;
  logic             hit_s;

  assign load_s = ~valid_q | ready_i;

  // Arbitration: scan indices >= start first, then wrap to the low indices.
  always_comb begin
    start_s     = mode_i ? ptr_q : '0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < channels; k++) begin
      hit_s       = ~win_found_s & valid_i[k] & (sel_w'(k) >= start_s);
      win_idx_s   = hit_s ? sel_w'(k) : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
    for (int k = 0; k < channels; k++) begin
      hit_s       = ~win_found_s & valid_i[k];
      win_idx_s   = hit_s ? sel_w'(k) : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // Winner's data word and the per-channel accept strobes.
  always_comb begin
    win_data_s = '0;
    ready_o    = '0;
    for (int k = 0; k < channels; k++) begin
      win_data_s = (sel_w'(k) == win_idx_s) ? data_i[k*size +: size] : win_data_s;
      ready_o[k] = load_s & win_found_s & ~rst_i & (sel_w'(k) == win_idx_s);
    end
  end

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (load_s) begin
      if (win_found_s) begin
        data_d  = win_data_s;
        grant_d = win_idx_s;
        valid_d = 1'b1;
        if (mode_i) begin
          ptr_d = (win_idx_s == LastIdx) ? '0 : win_idx_s + OneIdx;
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Self-checking bench for mux_arb_nto1: a 4-channel and a 3-channel instance
// compared each cycle against an arithmetic model, plus directed literal checks.
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         mode_a, rdy_a, mode_b, rdy_b;
  logic [3:0]   valid_a;
  logic [127:0] data_a;
  logic [2:0]   valid_b;
  logic [95:0]  data_b;
  logic [3:0]   ready_a;
  logic [2:0]   ready_b;
  logic [31:0]  dout_a, dout_b;
  logic         vout_a, vout_b;
  logic [1:0]   grant_a, grant_b;

  int checks = 0;
  int errors = 0;

  mux_arb_nto1 #(.size(32), .channels(4), .sel_w(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_a), .valid_i(valid_a), .data_i(data_a),
    .ready_o(ready_a), .data_o(dout_a), .valid_o(vout_a), .grant_o(grant_a), .ready_i(rdy_a)
  );

  mux_arb_nto1 #(.size(32), .channels(3), .sel_w(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .mode_i(mode_b), .valid_i(valid_b), .data_i(data_b),
    .ready_o(ready_b), .data_o(dout_b), .valid_o(vout_b), .grant_o(grant_b), .ready_i(rdy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state per instance: output register contents and rotation pointer.
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  int          m_grant [2];
  int          m_ptr   [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_data[d] = 32'h0; m_grant[d] = 0; m_ptr[d] = 0;
    end
  end

  function automatic int pick(input logic [15:0] v, input int n, input int start);
    for (int i = 0; i < n; i++) begin
      if (v[(start + i) % n]) return (start + i) % n;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input int n, input logic mode, input logic rdy,
                            input logic [15:0] v, input logic [127:0] dat,
                            input logic [15:0] dut_ready, input logic dut_valid,
                            input logic [31:0] dut_data, input int dut_grant);
    logic        load;
    int          w;
    logic [15:0] exp_ready;
    load = !m_valid[d] || rdy;
    w = pick(v, n, mode ? m_ptr[d] : 0);
    exp_ready = (rst || !load || w < 0) ? 16'h0 : (16'h1 << w);
    chk($sformatf("ready_o[%0d]", d), {16'h0, dut_ready}, {16'h0, exp_ready});
    chk($sformatf("valid_o[%0d]", d), {31'h0, dut_valid}, {31'h0, m_valid[d]});
    chk($sformatf("data_o[%0d]", d), dut_data, m_data[d]);
    chk($sformatf("grant_o[%0d]", d), dut_grant, m_grant[d]);
    if (rst) begin
      m_valid[d] = 1'b0; m_data[d] = 32'h0; m_grant[d] = 0; m_ptr[d] = 0;
    end else if (load) begin
      if (w >= 0) begin
        m_valid[d] = 1'b1;
        m_data[d]  = dat[w*32 +: 32];
        m_grant[d] = w;
        if (mode) m_ptr[d] = (w + 1) % n;
      end else begin
        m_valid[d] = 1'b0;
      end
    end
  endtask

  // Single compare process: inputs are stable between negedge and the next posedge.
  always @(negedge clk) begin
    model_step(0, 4, mode_a, rdy_a, {12'h0, valid_a}, data_a,
               {12'h0, ready_a}, vout_a, dout_a, int'(grant_a));
    model_step(1, 3, mode_b, rdy_b, {13'h0, valid_b}, {32'h0, data_b},
               {13'h0, ready_b}, vout_b, dout_b, int'(grant_b));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [1:0] g, input logic [31:0] dat, input logic v);
    chk({name, " grant"}, {30'h0, grant_a}, {30'h0, g});
    chk({name, " data"}, dout_a, dat);
    chk({name, " valid"}, {31'h0, vout_a}, {31'h0, v});
  endtask

  initial begin
    rst = 1'b1; mode_a = 1'b0; rdy_a = 1'b1; valid_a = 4'b1111; data_a = '0;
    mode_b = 1'b0; rdy_b = 1'b1; valid_b = 3'b000; data_b = '0;
    #1;
    chk("ready during reset", {28'h0, ready_a}, 32'h0);
    tick(); tick();
    chk_a("reset", 2'd0, 32'h0, 1'b0);
    rst = 1'b0; valid_a = 4'b0000;
    tick();

    // Fixed priority
    valid_a = 4'b1110; data_a = {32'h33, 32'h22, 32'h11, 32'h00};
    #1;
    chk("fixed ready", {28'h0, ready_a}, 32'h2);
    tick(); chk_a("fixed 1st", 2'd1, 32'h11, 1'b1);
    tick(); chk_a("fixed 2nd", 2'd1, 32'h11, 1'b1);
    valid_a = 4'b1100;
    tick(); chk_a("fixed drop1", 2'd2, 32'h22, 1'b1);

    // Round robin fairness (pointer still 0: fixed mode never moves it)
    mode_a = 1'b1; valid_a = 4'b1111;
    tick(); chk_a("rr0", 2'd0, 32'h00, 1'b1);
    tick(); chk_a("rr1", 2'd1, 32'h11, 1'b1);
    tick(); chk_a("rr2", 2'd2, 32'h22, 1'b1);
    tick(); chk_a("rr3", 2'd3, 32'h33, 1'b1);
    tick(); chk_a("rr4", 2'd0, 32'h00, 1'b1);
    tick(); chk_a("rr5", 2'd1, 32'h11, 1'b1);

    // Pointer wrap after ch3
    tick(); chk_a("wrap pre2", 2'd2, 32'h22, 1'b1);
    tick(); chk_a("wrap pre3", 2'd3, 32'h33, 1'b1);
    valid_a = 4'b0101;
    tick(); chk_a("wrap ch0", 2'd0, 32'h00, 1'b1);
    tick(); chk_a("wrap ch2", 2'd2, 32'h22, 1'b1);

    // Backpressure (pointer now 3)
    valid_a = 4'b1111; data_a = {32'hAA, 32'h22, 32'h11, 32'h00};
    tick(); chk_a("bp load", 2'd3, 32'hAA, 1'b1);
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp ready", {28'h0, ready_a}, 32'h0);
      tick(); chk_a("bp hold", 2'd3, 32'hAA, 1'b1);
    end
    rdy_a = 1'b1;
    #1;
    chk("bp release ready", {28'h0, ready_a}, 32'h1);
    tick(); chk_a("bp release", 2'd0, 32'h00, 1'b1);

    // Drain with no requests
    valid_a = 4'b0000;
    tick();
    chk("drain valid", {31'h0, vout_a}, 32'h0);
    chk("drain ready", {28'h0, ready_a}, 32'h0);

    // Mid-operation reset with ptr=2
    valid_a = 4'b0010;
    tick(); chk_a("pre-reset", 2'd1, 32'h11, 1'b1);
    rst = 1'b1; valid_a = 4'b1111;
    #1;
    chk("reset ready", {28'h0, ready_a}, 32'h0);
    tick(); chk_a("mid reset", 2'd0, 32'h0, 1'b0);
    rst = 1'b0;
    tick(); chk_a("post reset", 2'd0, 32'h00, 1'b1);
    valid_a = 4'b0000;

    // Three-channel build: scan wraps after ch2
    mode_b = 1'b1; valid_b = 3'b111; data_b = {32'hB2, 32'hB1, 32'hB0};
    tick(); chk("b grant0", {30'h0, grant_b}, 32'd0);
    tick(); chk("b grant1", {30'h0, grant_b}, 32'd1);
    tick(); chk("b grant2", {30'h0, grant_b}, 32'd2);
    tick(); chk("b wrap0", {30'h0, grant_b}, 32'd0);
    chk("b wrap data", dout_b, 32'hB0);
    valid_b = 3'b000;

    // Pseudo-random tail, checked by the model only
    for (int i = 0; i < 80; i++) begin
      rst     = ($urandom_range(0, 24) == 0);
      mode_a  = 1'($urandom_range(0, 1));
      rdy_a   = ($urandom_range(0, 3) != 0);
      valid_a = 4'($urandom);
      data_a  = {$urandom, $urandom, $urandom, $urandom};
      mode_b  = 1'($urandom_range(0, 1));
      rdy_b   = ($urandom_range(0, 3) != 0);
      valid_b = 3'($urandom);
      data_b  = {$urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0; valid_a = '0; valid_b = '0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
- Parametrised N-to-1 data-path multiplexer, the successor to the 2-to-1 select mux.
- Selection is driven by an internal arbiter (fixed-priority or round-robin), not by an external select line.
- Output is a one-deep registered stage with valid/ready handshake.
- Merges several requesters (e.g. writeback or memory-request sources) onto one shared channel in the pipelined CPU.

Parameters:
- size, 32, data width per channel in bits (≥1)
- channels, 4, number of input channels (2..16; power of two not required)
- sel_w, 2, width of grant index; 2^sel_w ≥ channels

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- mode_i  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
- valid_i  input  channels  per-channel request valid
- data_i  input  channels*size  flattened inputs; channel k occupies bits [k*size +: size]
- ready_o  output  channels  per-channel accept, combinational
- data_o  output  size  registered selected data
- valid_o  output  1  data_o holds an untaken item
- grant_o  output  sel_w  index of the channel whose data is in data_o
- ready_i  input  1  downstream accept

Behaviour:
- Reset: while rst_i=1 at a clock edge, the following are cleared:
  - valid_o=0, data_o=0, grant_o=0, rr pointer=0.
  - ready_o is forced to all-zero whenever rst_i=1, including the reset cycle itself.
  - Reset mid-transfer discards the held item; no handshake completes in that cycle.
- Load enable: load = ~valid_o | ready_i.
  - The output register accepts a new item only when load=1.
  - There is no skid buffer, so full throughput (1 item/cycle) is reached only while ready_i=1.
- Arbitration (combinational, every cycle):
  - Candidate set = {k : valid_i[k]=1}.
  - Fixed mode: winner = lowest k in the set.
  - Round-robin mode: winner = first k in the set scanning ptr, ptr+1, …, channels-1, 0, …, ptr-1 (wrap mod channels, valid for non-power-of-two channel counts).
  - No candidates → no winner.
- ready_o[k] = load & (k is winner) & ~rst_i. At most one bit is set per cycle. Upstream must not make valid_i depend on ready_o.
- Transfer: a transfer from channel k occurs when valid_i[k] & ready_o[k]. On that edge:
  - data_o ← data_i[k]
  - grant_o ← k
  - valid_o ← 1
- Latency: 1 cycle from input accept to valid_o.
- Output drain:
  - If load=1 and there is no winner: valid_o ← 0. data_o and grant_o hold their last values (don't-care to downstream).
  - If valid_o=1 and ready_i=0: data_o, grant_o and valid_o hold stable; all ready_o=0.
- Simultaneous drain and accept: with valid_o=1, ready_i=1 and a winner present, the old item leaves and the new item loads in the same edge. valid_o stays 1.
- Pointer update:
  - On a transfer in round-robin mode: ptr ← (k+1) mod channels; k=channels-1 wraps to 0.
  - In fixed mode, ptr is unchanged.
- Mode change: mode_i is sampled combinationally. A change takes effect in that cycle's arbitration; the ptr value is retained across mode switches.
- Arithmetic: all index math is sel_w bits wide. Wrap uses an explicit compare with channels-1, not natural overflow.

Test Plan:
- Fixed priority, defaults, mode_i=0, valid_i=4'b1110, data ch1..3 = 0x11, 0x22, 0x33, ready_i=1 held →
  - grants go 1,1,1… while all stay valid; data_o=0x11 one cycle after the first accept.
  - Dropping valid_i[1] → next grant_o=2.
- Round-robin fairness, mode_i=1, valid_i=4'b1111 constant, ready_i=1 →
  - grant_o sequence 0,1,2,3,0,1; valid_o=1 every cycle after the first.
  - ready_o one-hot, rotating.
- Pointer wrap, mode_i=1, after a grant to ch3, only valid_i[0]=1 and valid_i[2]=1 →
  - next grant=0 (ptr wrapped to 0), then 2.
  - channels=3 build: after a grant to ch2, next scan starts at 0.
- Backpressure, valid_o=1 with data_o=0xAA, ready_i=0 for 3 cycles while valid_i=4'b1111 →
  - data_o=0xAA and grant_o stable; ready_o=0 for all 3 cycles.
  - On ready_i=1, the new item loads on the same edge; valid_o stays 1.
- Drain with no requests, valid_o=1, ready_i=1, valid_i=0 → next cycle valid_o=0, ready_o=0.
- Mid-operation reset, rst_i=1 for 1 cycle while valid_o=1 and ptr=2 →
  - valid_o=0, data_o=0, grant_o=0, ready_o=0 during reset.
  - After release with valid_i=4'b1111 in round-robin mode, first grant=0.
